mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage in the 5-stage RV32 pipeline.
- Consumes the EX result (ALU value/address, store data = rs2, destination info), performs loads/stores to data memory over a req/ack handshake, and formats load data (byte/half/word, sign/zero extension).
- Produces registered write-back data for WB and stalls upstream stages while an access is outstanding.

---
 rtl/mem_stage_pkg.sv | 55 +++++
 rtl/mem_align.sv | 67 ++++++
 rtl/mem_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage:
//   - REG_BUS      : register / data-bus width
//   - mem_op_e     : memory operation carried down from EX
//   - mem_state_e  : MEM stage FSM states
//   - LANE_*       : byte-enable patterns for a naturally aligned access at lane 0
//   - helper functions classifying an operation (load/store/misaligned)
// Optional feature macro used by the users of this package: MEM_MISALIGN_EXC_EN.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int REG_BUS = 32;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_HALF = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;

    function automatic logic op_is_load(input mem_op_e op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
    function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
        logic half;
        logic word;
        half = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word = (op == MEM_LW) || (op == MEM_SW);
        return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Purely combinational lane steering for the MEM stage. The same block serves
// the request side (byte enables + store data replicated into lanes) and the
// response side (load extract + sign/zero extension).
// Address low bits are forced to natural alignment here (half: bit0=0,
// word: bits[1:0]=0), so a misaligned access degrades to the aligned one.
// Ports:
//   op          in   mem_op_e  operation
//   addr_lo     in   2         effective address [1:0]
//   store_data  in   32        rs2 value for stores
//   load_word   in   32        raw word returned by data memory
//   byte_en     out  4         write byte enables (0000 for non-stores)
//   lane_data   out  32        store data replicated into every lane
//   load_data   out  32        formatted load result
// -----------------------------------------------------------------------------
module mem_align
    import mem_stage_pkg::*;
(
    input  mem_op_e             op,
    input  logic [1:0]          addr_lo,
    input  logic [REG_BUS-1:0]  store_data,
    input  logic [REG_BUS-1:0]  load_word,
    output logic [3:0]          byte_en,
    output logic [REG_BUS-1:0]  lane_data,
    output logic [REG_BUS-1:0]  load_data
);

    logic [1:0]         lane;
    logic [REG_BUS-1:0] shifted;

    always_comb begin
        lane = addr_lo;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: lane = {addr_lo[1], 1'b0};
            MEM_LW, MEM_SW:          lane = 2'b00;
            default:                 lane = addr_lo;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = load_word >> {lane, 3'b000};

    always_comb begin
        byte_en   = LANE_NONE;
        lane_data = store_data;
        load_data = '0;
        case (op)
            MEM_SB: begin
                byte_en   = LANE_BYTE << lane;
                lane_data = {4{store_data[7:0]}};
            end
            MEM_SH: begin
                byte_en   = LANE_HALF << lane;
                lane_data = {2{store_data[15:0]}};
            end
            MEM_SW:  byte_en = LANE_WORD;
            MEM_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LBU: load_data = {24'b0, shifted[7:0]};
            MEM_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LHU: load_data = {16'b0, shifted[15:0]};
            MEM_LW:  load_data = load_word;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 5-stage RV32 pipeline. Non-memory instructions
// pass straight to the MEM/WB register (latency 1). Loads and stores are sent
// to data memory over a req/ack handshake, the upstream pipeline is stalled
// while the access is outstanding, and the load result is lane-extracted and
// extended before being registered for write-back. An access with no ack for
// TIMEOUT_CYCLES cycles is aborted with a one-cycle bus_err_o pulse.
//
// Handshakes:
//   upstream: an instruction on valid_i is consumed on a rising edge where
//     stallreq_o is low; while stallreq_o is high the EX/MEM slot must hold.
//   memory: dm_req_o/dm_we_o/dm_addr_o/dm_wdata_o stay stable from the edge
//     req rises until the edge after dm_ack_i is seen; dm_rdata_i is sampled
//     only in the ack cycle. Ack in the first req cycle is legal.
//
// Optional feature macro: MEM_MISALIGN_EXC_EN
//   defined   - misaligned half/word ops issue no request; the op retires
//               with wb_wreg_o=0 and a one-cycle misalign_o pulse.
//   undefined - address low bits are masked to natural alignment.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid_i         EX/MEM slot live
//   memop_i         mem_op_e operation
//   alu_res_i       EX result / effective address
//   wdata_i         store data (rs2)
//   wd_i, wreg_i    destination register / write enable
//   dm_*            data-memory request/response
//   stallreq_o      freeze IF/ID/EX and EX/MEM
//   wb_*            registered MEM/WB outputs
//   bus_err_o       access timed out (pulse)
//   misalign_o      misaligned op (pulse, MEM_MISALIGN_EXC_EN only)
//   dbg_state       current FSM state
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic [3:0]          memop_i,
    input  logic [REG_BUS-1:0]  alu_res_i,
    input  logic [REG_BUS-1:0]  wdata_i,
    input  logic [4:0]          wd_i,
    input  logic                wreg_i,
    output logic                dm_req_o,
    output logic [3:0]          dm_we_o,
    output logic [REG_BUS-1:0]  dm_addr_o,
    output logic [REG_BUS-1:0]  dm_wdata_o,
    input  logic [REG_BUS-1:0]  dm_rdata_i,
    input  logic                dm_ack_i,
    output logic                stallreq_o,
    output logic                wb_valid_o,
    output logic [REG_BUS-1:0]  wb_data_o,
    output logic [4:0]          wb_wd_o,
    output logic                wb_wreg_o,
    output logic                bus_err_o,
`ifdef MEM_MISALIGN_EXC_EN
    output logic                misalign_o,
`endif
    output mem_state_e          dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e          state, state_next;
    logic [CNT_W-1:0]    cnt;
    mem_op_e             op, op_r;
    logic [1:0]          lane_r;
    logic [4:0]          wd_r;
    logic                wreg_r;

    logic                bypass, start_access, finish, abort, timeout_hit;
`ifdef MEM_MISALIGN_EXC_EN
    logic                misalign_hit;
`endif

    logic [3:0]          req_we;
    logic [REG_BUS-1:0]  req_wdata, req_load_unused;
    logic [3:0]          rsp_we_unused;
    logic [REG_BUS-1:0]  rsp_wdata_unused, rsp_load;
    logic                unused_align;

    assign op        = mem_op_e'(memop_i);
    assign dbg_state = state;

    // Request side: lanes/enables from the incoming EX instruction.
    mem_align u_req_align (
        .op         (op),
        .addr_lo    (alu_res_i[1:0]),
        .store_data (wdata_i),
        .load_word  ('0),
        .byte_en    (req_we),
        .lane_data  (req_wdata),
        .load_data  (req_load_unused)
    );

    // Response side: format the returned word with the captured op/lane.
    mem_align u_rsp_align (
        .op         (op_r),
        .addr_lo    (lane_r),
        .store_data ('0),
        .load_word  (dm_rdata_i),
        .byte_en    (rsp_we_unused),
        .lane_data  (rsp_wdata_unused),
        .load_data  (rsp_load)
    );

    assign unused_align = ^{req_load_unused, rsp_we_unused, rsp_wdata_unused};

    // Counter holds the number of ACCESS cycles already spent; the cycle in
    // which it would reach TIMEOUT_CYCLES without an ack is the abort cycle.
    assign timeout_hit = (state == MEM_ACCESS) && !dm_ack_i && (cnt == CNT_LAST);

    always_comb begin
        state_next   = state;
        stallreq_o   = 1'b0;
        bypass       = 1'b0;
        start_access = 1'b0;
        finish       = 1'b0;
        abort        = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
        misalign_hit = 1'b0;
`endif
        case (state)
            MEM_IDLE: begin
                if (valid_i) begin
                    if (op == MEM_NONE) begin
                        bypass = 1'b1;
                    end
`ifdef MEM_MISALIGN_EXC_EN
                    else if (op_misaligned(op, alu_res_i[1:0])) begin
                        misalign_hit = 1'b1;
                    end
`endif
                    else begin
                        start_access = 1'b1;
                        stallreq_o   = 1'b1;
                        state_next   = MEM_ACCESS;
                    end
                end
            end
            MEM_ACCESS: begin
                if (dm_ack_i) begin
                    finish     = 1'b1;
                    state_next = MEM_IDLE;
                end else if (timeout_hit) begin
                    // Release the stall in the abort cycle so the held
                    // instruction retires instead of being re-issued.
                    abort      = 1'b1;
                    state_next = MEM_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MEM_IDLE;
            cnt        <= '0;
            op_r       <= MEM_NONE;
            lane_r     <= 2'b00;
            wd_r       <= '0;
            wreg_r     <= 1'b0;
            dm_req_o   <= 1'b0;
            dm_we_o    <= '0;
            dm_addr_o  <= '0;
            dm_wdata_o <= '0;
            wb_valid_o <= 1'b0;
            wb_data_o  <= '0;
            wb_wd_o    <= '0;
            wb_wreg_o  <= 1'b0;
            bus_err_o  <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            bus_err_o  <= 1'b0;
            wb_valid_o <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
            misalign_o <= 1'b0;
            if (misalign_hit) begin
                wb_valid_o <= 1'b1;
                wb_data_o  <= '0;
                wb_wd_o    <= wd_i;
                wb_wreg_o  <= 1'b0;
                misalign_o <= 1'b1;
            end
`endif
            if (bypass) begin
                wb_valid_o <= 1'b1;
                wb_data_o  <= alu_res_i;
                wb_wd_o    <= wd_i;
                wb_wreg_o  <= wreg_i;
            end
            if (start_access) begin
                dm_req_o   <= 1'b1;
                dm_we_o    <= req_we;
                dm_addr_o  <= {alu_res_i[REG_BUS-1:2], 2'b00};
                dm_wdata_o <= req_wdata;
                op_r       <= op;
                lane_r     <= alu_res_i[1:0];
                wd_r       <= wd_i;
                wreg_r     <= wreg_i;
                cnt        <= '0;
            end
            if (state == MEM_ACCESS) begin
                cnt <= cnt + 1'b1;
            end
            if (finish) begin
                dm_req_o   <= 1'b0;
                dm_we_o    <= '0;
                wb_valid_o <= 1'b1;
                wb_wd_o    <= wd_r;
                wb_wreg_o  <= op_is_load(op_r) ? wreg_r : 1'b0;
                wb_data_o  <= op_is_load(op_r) ? rsp_load : '0;
            end
            if (abort) begin
                dm_req_o   <= 1'b0;
                dm_we_o    <= '0;
                wb_valid_o <= 1'b1;
                wb_wd_o    <= wd_r;
                wb_wreg_o  <= 1'b0;
                wb_data_o  <= '0;
                bus_err_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. A driver issues instructions (directed
// cases then random ones) and holds them while stallreq_o is high. A memory
// responder acknowledges each request after a chosen delay (or never, to force
// a timeout) and checks the request fields. A monitor pops the expected
// write-back record whenever wb_valid_o is seen.
// Optional feature macro honoured: MEM_MISALIGN_EXC_EN.
// -----------------------------------------------------------------------------
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [3:0]  memop_i;
    logic [31:0] alu_res_i, wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        dm_req_o;
    logic [3:0]  dm_we_o;
    logic [31:0] dm_addr_o, dm_wdata_o;
    logic [31:0] dm_rdata_i;
    logic        dm_ack_i;
    logic        stallreq_o;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic        bus_err_o;
`ifdef MEM_MISALIGN_EXC_EN
    logic        misalign_o;
`endif
    mem_state_e  dbg_state;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .memop_i    (memop_i),
        .alu_res_i  (alu_res_i),
        .wdata_i    (wdata_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .dm_req_o   (dm_req_o),
        .dm_we_o    (dm_we_o),
        .dm_addr_o  (dm_addr_o),
        .dm_wdata_o (dm_wdata_o),
        .dm_rdata_i (dm_rdata_i),
        .dm_ack_i   (dm_ack_i),
        .stallreq_o (stallreq_o),
        .wb_valid_o (wb_valid_o),
        .wb_data_o  (wb_data_o),
        .wb_wd_o    (wb_wd_o),
        .wb_wreg_o  (wb_wreg_o),
        .bus_err_o  (bus_err_o),
`ifdef MEM_MISALIGN_EXC_EN
        .misalign_o (misalign_o),
`endif
        .dbg_state  (dbg_state)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  wd;
        logic        wreg;
        logic        chk_data;
        logic        err;
        logic        mis;
    } wb_exp_t;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [31:0] rdata;
        int          delay;
        logic        noack;
    } mem_exp_t;

    wb_exp_t  exp_q[$];
    mem_exp_t mem_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_ld(input mem_op_e op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [31:0] addr);
        if (op inside {MEM_LH, MEM_LHU, MEM_SH}) return addr[0];
        if (op inside {MEM_LW, MEM_SW}) return addr[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input mem_op_e op, input logic [31:0] addr,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
        h = (w >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
        case (op)
            MEM_LB:  return b[7] ? (b | 32'hFFFF_FF00) : b;
            MEM_LBU: return b;
            MEM_LH:  return h[15] ? (h | 32'hFFFF_0000) : h;
            MEM_LHU: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_we(input mem_op_e op, input logic [31:0] addr);
        case (op)
            MEM_SB:  return 4'(1 << addr[1:0]);
            MEM_SH:  return addr[1] ? 4'b1100 : 4'b0011;
            MEM_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input mem_op_e op, input logic [31:0] d);
        case (op)
            MEM_SB:  return {4{d[7:0]}};
            MEM_SH:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input mem_op_e op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] rdata,
                         input int delay, input logic noack);
        wb_exp_t  e;
        mem_exp_t m;
        int exp_stall, stalls, cyc;
        logic done, mis;
        mis = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
        mis = is_misaligned(op, addr);
`endif
        e.data = '0; e.wd = wd; e.wreg = 1'b0; e.chk_data = 1'b0; e.err = 1'b0; e.mis = 1'b0;
        if (op == MEM_NONE) begin
            e.data = addr; e.wreg = wreg; e.chk_data = 1'b1;
            exp_stall = 0;
        end else if (mis) begin
            e.mis = 1'b1;
            exp_stall = 0;
        end else begin
            m.we = model_we(op, addr);
            m.addr = addr & 32'hFFFF_FFFC;
            m.wdata = model_wdata(op, sdata);
            m.chk_wdata = !is_ld(op);
            m.rdata = rdata; m.delay = delay; m.noack = noack;
            mem_q.push_back(m);
            if (noack) begin
                e.err = 1'b1;
                exp_stall = TIMEOUT;
            end else begin
                if (is_ld(op)) begin
                    e.data = model_load(op, addr, rdata); e.wreg = wreg; e.chk_data = 1'b1;
                end
                exp_stall = 1 + delay;
            end
        end
        exp_q.push_back(e);
        valid_i = 1'b1; memop_i = op; alu_res_i = addr; wdata_i = sdata; wd_i = wd; wreg_i = wreg;
        done = 1'b0; cyc = 0; stalls = 0;
        while (!done && cyc < 100) begin
            #2;
            if (stallreq_o) stalls++;
            else done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("accepted", 32'(done), 32'd1);
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        valid_i = 1'b0;
        memop_i = 4'(MEM_NONE);
    endtask

    // ---------------- memory responder ----------------
    initial begin : responder
        mem_exp_t m;
        logic busy;
        int cnt;
        busy = 1'b0; cnt = 0;
        dm_ack_i = 1'b0; dm_rdata_i = '0;
        forever begin
            @(negedge clk);
            dm_ack_i = 1'b0;
            dm_rdata_i = $urandom;
            if (rst) begin
                busy = 1'b0;
            end else begin
                if (busy && !dm_req_o) begin
                    check("timeout_req_cycles", 32'(cnt), 32'(TIMEOUT));
                    busy = 1'b0;
                end
                if (dm_req_o && !busy) begin
                    if (mem_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: got req=1 expected req=0 at %0t", $time);
                    end else begin
                        m = mem_q.pop_front();
                        busy = 1'b1; cnt = 0;
                        check("dm_addr", dm_addr_o, m.addr);
                        check("dm_we", 32'(dm_we_o), 32'(m.we));
                        if (m.chk_wdata) check("dm_wdata", dm_wdata_o, m.wdata);
                    end
                end
                if (busy) begin
                    if (!m.noack && cnt == m.delay) begin
                        dm_ack_i = 1'b1;
                        dm_rdata_i = m.rdata;
                        busy = 1'b0;
                    end
                    cnt++;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && wb_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wb: got wb_valid=1 expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_wreg", 32'(wb_wreg_o), 32'(e.wreg));
                    check("bus_err", 32'(bus_err_o), 32'(e.err));
`ifdef MEM_MISALIGN_EXC_EN
                    check("misalign", 32'(misalign_o), 32'(e.mis));
`endif
                    if (e.chk_data) begin
                        check("wb_data", wb_data_o, e.data);
                        check("wb_wd", 32'(wb_wd_o), 32'(e.wd));
                    end
                end
            end else if (!rst && bus_err_o) begin
                checks++; errors++;
                $display("FAIL stray_bus_err: got 1 expected 0 at %0t", $time);
            end
        end
    end

    // ---------------- clock/reset + sequence ----------------
    initial begin : main
        int cyc;
        mem_exp_t m;
        rst = 1'b1; valid_i = 1'b0; memop_i = 4'(MEM_NONE);
        alu_res_i = '0; wdata_i = '0; wd_i = '0; wreg_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dm_req", 32'(dm_req_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(MEM_IDLE));
        rst = 1'b0;

        issue(MEM_NONE, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 32'h0, 0, 1'b0);
        issue(MEM_LB,   32'h0000_0103, 32'h0, 5'd7, 1'b1, 32'h80FF_0011, 3, 1'b0);
        issue(MEM_SH,   32'h0000_0202, 32'hDEAD_BEEF, 5'd9, 1'b1, 32'h0, 0, 1'b0);
        issue(MEM_LHU,  32'h0000_0000, 32'h0, 5'd10, 1'b1, 32'h0000_F00D, 1, 1'b0);
        issue(MEM_LW,   32'h0000_0000, 32'h0, 5'd11, 1'b1, 32'h0000_F00D, 2, 1'b0);
        issue(MEM_LW,   32'h0000_0300, 32'h0, 5'd12, 1'b1, 32'h0, 0, 1'b1);
        issue(MEM_NONE, 32'h0000_5678, 32'h0, 5'd13, 1'b1, 32'h0, 0, 1'b0);
        issue(MEM_LW,   32'h0000_0040, 32'h0, 5'd0, 1'b1, 32'hCAFE_BABE, 0, 1'b0);
        issue(MEM_SB,   32'h0000_0041, 32'h1234_56A5, 5'd3, 1'b1, 32'h0, 2, 1'b0);
        issue(MEM_LH,   32'h0000_0082, 32'h0, 5'd4, 1'b1, 32'h9ABC_1234, 1, 1'b0);
        issue(MEM_LW,   32'h0000_0006, 32'h0, 5'd6, 1'b1, 32'h1111_2222, 1, 1'b0);
        issue(MEM_LH,   32'h0000_0003, 32'h0, 5'd8, 1'b1, 32'h8001_7FFF, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            issue(mem_op_e'($urandom_range(0, 8)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4),
                  ($urandom_range(0, 19) == 0));
        end

        // Reset while an access is outstanding: request drops, nothing retires.
        m.we = 4'b0000; m.addr = 32'h0000_0500; m.wdata = '0; m.chk_wdata = 1'b0;
        m.rdata = '0; m.delay = 0; m.noack = 1'b1;
        mem_q.push_back(m);
        valid_i = 1'b1; memop_i = 4'(MEM_LW); alu_res_i = 32'h0000_0500; wd_i = 5'd3; wreg_i = 1'b1;
        repeat (3) @(negedge clk);
        check("req_before_rst", 32'(dm_req_o), 32'd1);
        rst = 1'b1; valid_i = 1'b0; memop_i = 4'(MEM_NONE);
        @(negedge clk);
        check("midrst_dm_req", 32'(dm_req_o), 32'd0);
        check("midrst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("midrst_wb_data", wb_data_o, 32'd0);
        check("midrst_wb_wd", 32'(wb_wd_o), 32'd0);
        check("midrst_wb_wreg", 32'(wb_wreg_o), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(MEM_IDLE));
        rst = 1'b0;
        mem_q.delete();
        issue(MEM_NONE, 32'h0000_00AB, 32'h0, 5'd1, 1'b1, 32'h0, 0, 1'b0);

        cyc = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
